tt_sweep_checker: RTL and testbench

Sequential stimulus/check stage placed directly upstream of the 8-input, single-output optimized combinational netlist (`top`, inputs x0..x7, output y0). It accepts a 256-bit golden truth table over a serial handshake, sweeps all 256 input minterms into the netlist one per clock, samples y0 and compares against the golden table. It reports mismatch count, first failing minterm and on-set size for the autosymmetry experiment flow.

---
 rtl/tt_chk_pkg.sv | 25 ++
 rtl/tt_gold_store.sv | 38 +++
 rtl/tt_sweep_checker.sv | 164 ++++++++++++++++
 tb/tb_tt_sweep_checker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tt_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_chk_pkg
// Description : Shared constants and types for the truth-table sweep checker.
//               N_IN    - netlist input count
//               TT_BITS - golden table depth (2^N_IN)
//               CNT_W   - width of the result counters (holds 0..TT_BITS)
//               tt_state_e - checker state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package tt_chk_pkg;

  localparam int N_IN    = 8;
  localparam int TT_BITS = 1 << N_IN;
  localparam int CNT_W   = N_IN + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2,
    DONE  = 2'd3
  } tt_state_e;

endpackage : tt_chk_pkg
`default_nettype wire

// File: rtl/tt_gold_store.sv
`default_nettype none
// ============================================================================
// Module      : tt_gold_store
// Description : Golden truth-table storage. One bit per minterm, written by
//               index during load, read combinationally by index during sweep.
//               Contents are deliberately not reset: a fresh load always
//               precedes any sweep, so reset flops would add nothing.
// Ports       : clk    - clock, rising edge
//               wr_en  - write strobe
//               wr_idx - write minterm index
//               wr_bit - golden bit to store
//               rd_idx - read minterm index
//               rd_bit - stored golden bit at rd_idx
// Revision    : 1.0 - initial release
// ============================================================================
module tt_gold_store
  import tt_chk_pkg::*;
(
  input  logic            clk,
  input  logic            wr_en,
  input  logic [N_IN-1:0] wr_idx,
  input  logic            wr_bit,
  input  logic [N_IN-1:0] rd_idx,
  output logic            rd_bit
);

  logic [TT_BITS-1:0] r_table;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_table[wr_idx] <= wr_bit;
    end
  end

  assign rd_bit = r_table[rd_idx];

endmodule : tt_gold_store
`default_nettype wire

// File: rtl/tt_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tt_sweep_checker
// Description : Loads a golden truth table over a valid/ready serial port,
//               then drives every minterm into the downstream netlist one per
//               clock, compares the netlist output against the golden table
//               and reports mismatch count, first failing minterm and on-set
//               size.
// Ports       : clk            - clock, rising edge
//               rst            - asynchronous active-high reset
//               start          - pulse, begins load+sweep (IDLE/DONE only)
//               gold_vld       - golden bit valid
//               gold_bit       - golden bit, minterm 0 first
//               gold_rdy       - ready for golden bits (LOAD only)
//               x              - registered netlist stimulus
//               y              - netlist output, combinational from x
//               busy           - LOAD or SWEEP in progress
//               done           - results valid
//               pass           - no mismatches (valid with done)
//               err_cnt        - mismatch count
//               ones_cnt       - number of minterms with y==1
//               first_fail     - lowest mismatching minterm
//               first_fail_vld - at least one mismatch seen
// Revision    : 1.0 - initial release
// ============================================================================
module tt_sweep_checker
  import tt_chk_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gold_vld,
  input  logic             gold_bit,
  output logic             gold_rdy,
  output logic [N_IN-1:0]  x,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [N_IN-1:0]  first_fail,
  output logic             first_fail_vld
);

  tt_state_e        r_state;
  tt_state_e        w_state_nxt;
  logic [N_IN-1:0]  r_idx;
  logic [N_IN-1:0]  r_x;
  logic [CNT_W-1:0] r_err;
  logic [CNT_W-1:0] r_ones;
  logic [N_IN-1:0]  r_ff;
  logic             r_ffv;

  logic w_load_acc;
  logic w_load_last;
  logic w_sweep_last;
  logic w_gold_rd;
  logic w_mis;

  assign w_load_acc   = (r_state == LOAD) && gold_vld;
  assign w_load_last  = (r_idx == '1);
  assign w_sweep_last = (r_x == '1);
  assign w_mis        = (y != w_gold_rd);

  tt_gold_store u_store (
    .clk    (clk),
    .wr_en  (w_load_acc),
    .wr_idx (r_idx),
    .wr_bit (gold_bit),
    .rd_idx (r_x),
    .rd_bit (w_gold_rd)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    gold_rdy    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    pass        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = LOAD;
      end
      LOAD: begin
        gold_rdy = 1'b1;
        busy     = 1'b1;
        if (w_load_acc && w_load_last) w_state_nxt = SWEEP;
      end
      SWEEP: begin
        busy = 1'b1;
        if (w_sweep_last) w_state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        pass = (r_err == '0);
        if (start) w_state_nxt = LOAD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: load index, stimulus, counters and first-fail capture.
  // In SWEEP, r_x has been stable for a full cycle when y is sampled, so
  // the netlist only needs to close within one clock period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_x    <= '0;
      r_err  <= '0;
      r_ones <= '0;
      r_ff   <= '0;
      r_ffv  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_idx  <= '0;
            r_x    <= '0;
            r_err  <= '0;
            r_ones <= '0;
            r_ff   <= '0;
            r_ffv  <= 1'b0;
          end
        end
        LOAD: begin
          // Index wraps to 0 after the last bit, leaving it clean for reuse
          if (gold_vld) r_idx <= r_idx + N_IN'(1);
        end
        SWEEP: begin
          if (w_mis) begin
            r_err <= r_err + CNT_W'(1);
            if (!r_ffv) begin
              r_ff  <= r_x;
              r_ffv <= 1'b1;
            end
          end
          if (y) r_ones <= r_ones + CNT_W'(1);
          // Stimulus parks on the last minterm rather than wrapping
          if (!w_sweep_last) r_x <= r_x + N_IN'(1);
        end
        default: ;
      endcase
    end
  end

  assign x              = r_x;
  assign err_cnt        = r_err;
  assign ones_cnt       = r_ones;
  assign first_fail     = r_ff;
  assign first_fail_vld = r_ffv;

endmodule : tt_sweep_checker
`default_nettype wire

// File: tb/tb_tt_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_sweep_checker
// Description : Self-checking bench for tt_sweep_checker. A small behavioural
//               netlist model stands in for the downstream logic; golden
//               tables are derived from it and deliberately corrupted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_sweep_checker;
  import tt_chk_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             gold_vld;
  logic             gold_bit;
  logic             gold_rdy;
  logic [N_IN-1:0]  x;
  logic             y;
  logic             y_one;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] ones_cnt;
  logic [N_IN-1:0]  first_fail;
  logic             first_fail_vld;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Stand-in netlist
  function automatic logic net_f(input logic [7:0] v);
    return (v[0] & v[1]) ^ (v[2] | v[5]) ^ (v[7] & ~v[4]) ^ (v[6] & v[3]);
  endfunction

  assign y = y_one ? 1'b1 : net_f(x);

  tt_sweep_checker dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .gold_vld       (gold_vld),
    .gold_bit       (gold_bit),
    .gold_rdy       (gold_rdy),
    .x              (x),
    .y              (y),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .ones_cnt       (ones_cnt),
    .first_fail     (first_fail),
    .first_fail_vld (first_fail_vld)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".x"},        32'(x),              0);
    check({tag, ".gold_rdy"}, 32'(gold_rdy),       0);
    check({tag, ".busy"},     32'(busy),           0);
    check({tag, ".done"},     32'(done),           0);
    check({tag, ".pass"},     32'(pass),           0);
    check({tag, ".err"},      32'(err_cnt),        0);
    check({tag, ".ones"},     32'(ones_cnt),       0);
    check({tag, ".ff"},       32'(first_fail),     0);
    check({tag, ".ffv"},      32'(first_fail_vld), 0);
  endtask

  typedef struct {
    logic [255:0] gold;
    bit           y_one;
    bit           toggle;    // gold_vld every other cycle + stray starts
    int           exp_err;
    int           exp_ones;
    int           exp_ff;
    int           exp_ffv;
    int           exp_pass;
    int           exp_done;  // edges after the start edge until done seen
  } vec_t;

  // abort_x >= 0: assert rst when sweep reaches that minterm
  task automatic run_vec(input vec_t v, input string tag, input int abort_x);
    int idx;
    int k;
    int done_edge;
    logic vld;
    logic rdy_s;
    idx       = 0;
    k         = 0;
    done_edge = -1;
    y_one     = v.y_one;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    while (k < 2000) begin
      @(negedge clk);
      if (k == 0) begin
        check({tag, ".rdy_at_start+1"},  32'(gold_rdy),       1);
        check({tag, ".busy_at_start+1"}, 32'(busy),           1);
        check({tag, ".done_at_start+1"}, 32'(done),           0);
        check({tag, ".err_cleared"},     32'(err_cnt),        0);
        check({tag, ".ones_cleared"},    32'(ones_cnt),       0);
        check({tag, ".ffv_cleared"},     32'(first_fail_vld), 0);
      end
      if (done) begin
        done_edge = k;
        break;
      end
      if (abort_x >= 0 && idx >= 256 && busy && int'(x) == abort_x) begin
        start    = 1'b0;
        gold_vld = 1'b0;
        rst      = 1'b1;
        #1;
        check_reset({tag, ".async"});
        @(posedge clk);
        #1;
        check_reset({tag, ".held"});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset({tag, ".released"});
        return;
      end
      vld      = v.toggle ? (k % 2 == 1) : 1'b1;
      gold_vld = vld;
      gold_bit = (idx < 256) ? v.gold[idx] : 1'b0;
      start    = v.toggle && (k == 100 || k == 600);
      rdy_s    = gold_rdy;
      @(posedge clk);
      k++;
      if (vld && rdy_s) idx++;
    end
    start    = 1'b0;
    gold_vld = 1'b0;
    check({tag, ".done_edge"}, 32'(done_edge),      32'(v.exp_done));
    check({tag, ".err_cnt"},   32'(err_cnt),        32'(v.exp_err));
    check({tag, ".ones_cnt"},  32'(ones_cnt),       32'(v.exp_ones));
    check({tag, ".ff"},        32'(first_fail),     32'(v.exp_ff));
    check({tag, ".ffv"},       32'(first_fail_vld), 32'(v.exp_ffv));
    check({tag, ".pass"},      32'(pass),           32'(v.exp_pass));
    check({tag, ".busy"},      32'(busy),           0);
    check({tag, ".rdy"},       32'(gold_rdy),       0);
    check({tag, ".x_hold"},    32'(x),              255);
    // Results must stay put in DONE
    repeat (3) @(negedge clk);
    check({tag, ".done_hold"}, 32'(done),           1);
    check({tag, ".err_hold"},  32'(err_cnt),        32'(v.exp_err));
  endtask

  initial begin
    logic [255:0] exact;
    logic [255:0] g;
    int           pop;
    vec_t         tbl[6];

    rst      = 1'b1;
    start    = 1'b0;
    gold_vld = 1'b0;
    gold_bit = 1'b0;
    y_one    = 1'b0;

    pop = 0;
    for (int m = 0; m < 256; m++) begin
      exact[m] = net_f(8'(m));
      pop += int'(exact[m]);
    end

    // Exact table, continuous load
    tbl[0] = '{exact, 1'b0, 1'b0, 0, pop, 0, 0, 1, 512};
    // Bits 17 and 200 inverted
    g = exact; g[17] = ~g[17]; g[200] = ~g[200];
    tbl[1] = '{g, 1'b0, 1'b0, 2, pop, 17, 1, 0, 512};
    // All-zero golden, y tied high
    tbl[2] = '{256'b0, 1'b1, 1'b0, 256, 256, 0, 1, 0, 512};
    // Exact table, throttled load with ignored start pulses
    tbl[3] = '{exact, 1'b0, 1'b1, 0, pop, 0, 0, 1, 768};
    // Only the last minterm wrong
    g = exact; g[255] = ~g[255];
    tbl[4] = '{g, 1'b0, 1'b0, 1, pop, 255, 1, 0, 512};
    // First and last minterms wrong
    g = exact; g[0] = ~g[0]; g[255] = ~g[255];
    tbl[5] = '{g, 1'b0, 1'b0, 2, pop, 0, 1, 0, 512};

    // Reset values, with stray gold_vld while idle
    repeat (3) @(negedge clk);
    gold_vld = 1'b1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset("idle");
    gold_vld = 1'b0;

    // Back-to-back runs: each run after the first starts from DONE
    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i), -1);
    end

    // Reset in the middle of the sweep, then a fresh run
    run_vec(tbl[1], "abort", 100);
    run_vec(tbl[1], "after_abort", -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_tt_sweep_checker
`default_nettype wire
